// File: rtl/cluster_clock_gate_ctrl.sv
// Per-channel clock-gate controller: ACTIVE -> DRAIN -> GATED -> WAKE -> ACTIVE.
// Optional feature: define CLK_GATE_STATS_EN to add per-channel gated-cycle counters (gated_cnt_o).
module cluster_clock_gate_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_W      = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     test_en_i,
    input  logic [IDLE_W-1:0]        idle_thr_i,
    input  logic [NUM_CH-1:0]        busy_i,
    input  logic [NUM_CH-1:0]        force_on_i,
    input  logic [NUM_CH-1:0]        wake_req_i,
    output logic [NUM_CH-1:0]        clk_en_o,
    output logic [NUM_CH-1:0]        ready_o,
`ifdef CLK_GATE_STATS_EN
    output logic [NUM_CH-1:0][31:0]  gated_cnt_o,
`endif
    output logic [NUM_CH-1:0]        gated_o
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GATED  = 2'd2,
        ST_WAKE   = 2'd3
    } state_e;

    state_e            state_q    [NUM_CH];
    state_e            state_d    [NUM_CH];
    logic [IDLE_W-1:0] idle_cnt_q [NUM_CH];
    logic [IDLE_W-1:0] idle_cnt_d [NUM_CH];
    logic [3:0]        wake_cnt_q [NUM_CH];
    logic [3:0]        wake_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] idle;

    assign idle = ~(busy_i | force_on_i | wake_req_i);

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst_ni) begin
                state_q[i]    <= ST_ACTIVE;
                idle_cnt_q[i] <= '0;
                wake_cnt_q[i] <= '0;
            end else begin
                state_q[i]    <= state_d[i];
                idle_cnt_q[i] <= idle_cnt_d[i];
                wake_cnt_q[i] <= wake_cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]    = state_q[i];
            idle_cnt_d[i] = idle_cnt_q[i];
            wake_cnt_d[i] = wake_cnt_q[i];
            case (state_q[i])
                ST_ACTIVE: begin
                    if (idle[i] && (idle_thr_i != '0)) begin
                        state_d[i]    = ST_DRAIN;
                        idle_cnt_d[i] = '0;
                    end
                end
                ST_DRAIN: begin
                    if (!idle[i]) begin
                        state_d[i]    = ST_ACTIVE;
                        idle_cnt_d[i] = '0;
                    end else if (({1'b0, idle_cnt_q[i]} + (IDLE_W+1)'(1)) >= {1'b0, idle_thr_i}) begin
                        // Threshold is compared live, so lowering it mid-drain gates at once.
                        state_d[i]    = ST_GATED;
                        idle_cnt_d[i] = '0;
                    end else if (idle_cnt_q[i] != '1) begin
                        idle_cnt_d[i] = idle_cnt_q[i] + IDLE_W'(1);
                    end
                end
                ST_GATED: begin
                    if (!idle[i]) begin
                        state_d[i]    = (WAKE_CYCLES == 0) ? ST_ACTIVE : ST_WAKE;
                        wake_cnt_d[i] = '0;
                    end
                end
                ST_WAKE: begin
                    // Settling window ignores inputs entirely.
                    if (({1'b0, wake_cnt_q[i]} + 5'd1) >= 5'(WAKE_CYCLES)) begin
                        state_d[i]    = ST_ACTIVE;
                        wake_cnt_d[i] = '0;
                    end else begin
                        wake_cnt_d[i] = wake_cnt_q[i] + 4'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_ACTIVE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; test_en_i is the sole combinational path.
    always_comb begin
        clk_en_o = '0;
        ready_o  = '0;
        gated_o  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clk_en_o[i] = (state_q[i] != ST_GATED) || test_en_i;
            ready_o[i]  = (state_q[i] == ST_ACTIVE) || (state_q[i] == ST_DRAIN);
            gated_o[i]  = (state_q[i] == ST_GATED);
        end
    end

`ifdef CLK_GATE_STATS_EN
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst_ni) begin
                gated_cnt_o[i] <= '0;
            end else if ((state_q[i] == ST_GATED) && (gated_cnt_o[i] != '1)) begin
                gated_cnt_o[i] <= gated_cnt_o[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Scoreboard bench for cluster_clock_gate_ctrl: a run-length reference model predicts outputs after each edge.
module tb_cluster_clock_gate_ctrl;

    localparam int NUM_CH      = 4;
    localparam int IDLE_W      = 8;
    localparam int WAKE_CYCLES = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    test_en;
    logic [IDLE_W-1:0]       idle_thr;
    logic [NUM_CH-1:0]       busy, force_on, wake_req;
    logic [NUM_CH-1:0]       clk_en, ready, gated;
`ifdef CLK_GATE_STATS_EN
    logic [NUM_CH-1:0][31:0] gated_cnt;
`endif

    always #5 clk = ~clk;

    cluster_clock_gate_ctrl #(
        .NUM_CH      (NUM_CH),
        .IDLE_W      (IDLE_W),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_en_i   (test_en),
        .idle_thr_i  (idle_thr),
        .busy_i      (busy),
        .force_on_i  (force_on),
        .wake_req_i  (wake_req),
        .clk_en_o    (clk_en),
        .ready_o     (ready),
`ifdef CLK_GATE_STATS_EN
        .gated_cnt_o (gated_cnt),
`endif
        .gated_o     (gated)
    );

    typedef struct packed {
        logic [NUM_CH-1:0]       clk_en;
        logic [NUM_CH-1:0]       ready;
        logic [NUM_CH-1:0]       gated;
        logic [NUM_CH-1:0][31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: consecutive-idle run length, remaining wake cycles, gated flag.
    int          streak    [NUM_CH];
    int          wake_left [NUM_CH];
    bit          m_gated   [NUM_CH];
    logic [31:0] m_cnt     [NUM_CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [NUM_CH-1:0] sparse(input int one_in);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = ($urandom_range(0, one_in - 1) == 0);
        return v;
    endfunction

    task automatic drive(input logic [NUM_CH-1:0] b, input logic [NUM_CH-1:0] f,
                         input logic [NUM_CH-1:0] w, input logic te, input logic rn,
                         input int thr);
        @(negedge clk);
        busy     = b;
        force_on = f;
        wake_req = w;
        test_en  = te;
        rst_n    = rn;
        idle_thr = IDLE_W'(thr);
    endtask

    task automatic commit();
        exp_t e;
        bit   idle;
        int   thr;
        @(posedge clk);
        thr = int'(idle_thr);
        for (int i = 0; i < NUM_CH; i++) begin
            idle = !(busy[i] || force_on[i] || wake_req[i]);
            if (!rst_n) begin
                streak[i] = 0; wake_left[i] = 0; m_gated[i] = 0; m_cnt[i] = 0;
            end else if (m_gated[i]) begin
                m_cnt[i]++;
                if (!idle) begin
                    m_gated[i]   = 0;
                    wake_left[i] = WAKE_CYCLES;
                    streak[i]    = 0;
                end
            end else if (wake_left[i] > 0) begin
                wake_left[i]--;
            end else if (!idle) begin
                streak[i] = 0;
            end else if (thr != 0) begin
                // Gated once thr+1 consecutive idle edges have been seen.
                streak[i]++;
                if (streak[i] > thr) begin
                    m_gated[i] = 1;
                    streak[i]  = 0;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            e.gated[i]  = m_gated[i];
            e.ready[i]  = !m_gated[i] && (wake_left[i] == 0);
            e.clk_en[i] = !m_gated[i] || test_en;
            e.cnt[i]    = m_cnt[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [NUM_CH-1:0] b, input logic [NUM_CH-1:0] f,
                        input logic [NUM_CH-1:0] w, input logic te, input logic rn,
                        input int thr);
        drive(b, f, w, te, rn, thr);
        commit();
    endtask

    task automatic do_reset(input int thr, input logic [NUM_CH-1:0] b);
        step(b, '0, '0, 1'b0, 1'b0, thr);
        step(b, '0, '0, 1'b0, 1'b0, thr);
    endtask

    // Monitor: compares DUT outputs against each queued prediction after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clk_en", 64'(clk_en), 64'(e.clk_en));
                check("ready",  64'(ready),  64'(e.ready));
                check("gated",  64'(gated),  64'(e.gated));
`ifdef CLK_GATE_STATS_EN
                for (int i = 0; i < NUM_CH; i++)
                    check("gated_cnt", 64'(gated_cnt[i]), 64'(e.cnt[i]));
`endif
            end
        end
    end

    initial begin
        int thr;
        busy = '0; force_on = '0; wake_req = '0; test_en = 1'b0; rst_n = 1'b0; idle_thr = '0;

        // Reset values
        do_reset(3, '1);
        #2;
        check("rst_clk_en", 64'(clk_en), 64'hF);
        check("rst_ready",  64'(ready),  64'hF);
        check("rst_gated",  64'(gated),  64'h0);

        // ch0 goes idle at edge E with threshold 3: gated on E+3, not before
        step(4'b1110, '0, '0, 0, 1, 3);
        step(4'b1110, '0, '0, 0, 1, 3);
        step(4'b1110, '0, '0, 0, 1, 3);
        #2 check("gate_early", 64'(gated[0]), 64'd0);
        step(4'b1110, '0, '0, 0, 1, 3);
        #2;
        check("gate_at_thr", 64'(gated[0]),  64'd1);
        check("gate_clk_en", 64'(clk_en[0]), 64'd0);
        check("gate_ready",  64'(ready[0]),  64'd0);

        // Wake pulse: clock back immediately, ready after WAKE_CYCLES more edges
        step(4'b1110, '0, 4'b0001, 0, 1, 3);
        #2;
        check("wake_clk_en", 64'(clk_en[0]), 64'd1);
        check("wake_ready0", 64'(ready[0]),  64'd0);
        step(4'b1110, '0, '0, 0, 1, 3);
        #2 check("wake_ready1", 64'(ready[0]), 64'd0);
        step(4'b1110, '0, '0, 0, 1, 3);
        #2 check("wake_ready2", 64'(ready[0]), 64'd1);

        // Threshold 5, busy pulse at drain count 3 restarts the count
        do_reset(5, '1);
        for (int k = 0; k < 4; k++) step(4'b1110, '0, '0, 0, 1, 5);
        step(4'b1111, '0, '0, 0, 1, 5);
        #2 check("drain_abort", 64'({gated[0], ready[0]}), 64'b01);
        for (int k = 0; k < 5; k++) step(4'b1110, '0, '0, 0, 1, 5);
        #2 check("drain_restart", 64'(gated[0]), 64'd0);
        step(4'b1110, '0, '0, 0, 1, 5);
        #2 check("drain_regate", 64'(gated[0]), 64'd1);

        // Threshold 0 disables gating
        do_reset(0, '0);
        for (int k = 0; k < 300; k++) step('0, '0, '0, 0, 1, 0);
        #2;
        check("thr0_clk_en", 64'(clk_en), 64'hF);
        check("thr0_gated",  64'(gated),  64'h0);

        // All gated, test override is combinational and leaves state alone
        do_reset(1, '0);
        for (int k = 0; k < 3; k++) step('0, '0, '0, 0, 1, 1);
        drive('0, '0, '0, 1, 1, 1);
        #1;
        check("test_en_clk", 64'(clk_en), 64'hF);
        check("test_en_gated", 64'(gated), 64'hF);
        commit();
        #2 check("test_en_hold", 64'(gated), 64'hF);
        step('0, '0, 4'b1111, 0, 1, 1);
        #2 check("all_wake", 64'({ready, gated}), 64'h00);
        step('0, '0, '0, 0, 0, 1);
        #2 check("rst_mid_wake", 64'({clk_en, ready, gated}), 64'hFF0);

`ifdef CLK_GATE_STATS_EN
        do_reset(1, '1);
        step(4'b1101, '0, '0, 0, 1, 1);
        step(4'b1101, '0, '0, 0, 1, 1);
        for (int k = 0; k < 50; k++) step(4'b1101, '0, '0, 0, 1, 1);
        #2 check("stats_ch1_50", 64'(gated_cnt[1]), 64'd50);
`endif

        // Randomized segments, fixed threshold per segment, occasional resets
        for (int seg = 0; seg < 20; seg++) begin
            thr = int'($urandom_range(0, 6));
            do_reset(thr, '0);
            for (int k = 0; k < 150; k++)
                step(sparse(8), sparse(32), sparse(16), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 199) != 0), thr);
        end

        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
